// File: rtl/mac_sequencer.sv
// Sequencer for the Q8.8 MAC in the fully-connected layers: issues operand reads, clears the
// MAC between neurons and writes one result per neuron. Build macro SEQ_RELU_EN applies ReLU at write.
module mac_sequencer #(
  parameter int N_INPUTS  = 16,
  parameter int N_NEURONS = 8,
  parameter int IN_AW     = 4,
  parameter int NEU_AW    = 3,
  parameter int W_AW      = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IN_AW-1:0]  in_addr,
  output logic [W_AW-1:0]   w_addr,
  input  logic [15:0]       in_rdata,
  input  logic [15:0]       w_rdata,
  output logic [15:0]       mac_value,
  output logic [15:0]       mac_weight,
  output logic              mac_clr_n,
  input  logic [15:0]       mac_out,
  output logic              res_we,
  output logic [NEU_AW-1:0] res_addr,
  output logic [15:0]       res_data,
  output logic [2:0]        state_dbg
);

  // Handshake: start is a one-cycle request honoured only when busy is low (IDLE);
  // busy stays high from the cycle after acceptance through the one-cycle done pulse.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(N_INPUTS - 1);
  localparam logic [NEU_AW-1:0] N_LAST = NEU_AW'(N_NEURONS - 1);

  state_t             state;
  state_t             state_nx;
  logic [NEU_AW-1:0]  n;
  logic               drain_cnt;
  logic               rd_valid;
  logic [15:0]        res_hold;
  logic [15:0]        res_next;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLEAR;
      CLEAR:   state_nx = FEED;
      FEED:    if (in_addr == I_LAST) state_nx = DRAIN;
      DRAIN:   if (drain_cnt) state_nx = WRITE;
      WRITE:   state_nx = (n == N_LAST) ? DONE : CLEAR;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The MAC accumulates every cycle, so anything not backed by a read must enter as zero.
  assign mac_value  = rd_valid ? in_rdata : 16'h0000;
  assign mac_weight = rd_valid ? w_rdata  : 16'h0000;

`ifdef SEQ_RELU_EN
  assign res_next = mac_out[15] ? 16'h0000 : mac_out;
`else
  assign res_next = mac_out;
`endif

  // mac_out only settles during WRITE, so the word is forwarded then and held afterwards.
  assign res_data  = (state == WRITE) ? res_next : res_hold;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      n         <= '0;
      drain_cnt <= 1'b0;
      in_addr   <= '0;
      w_addr    <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      res_we    <= 1'b0;
      mac_clr_n <= 1'b0;
      res_addr  <= '0;
      res_hold  <= 16'h0000;
    end else begin
      state     <= state_nx;
      rd_valid  <= (state == FEED);
      done      <= (state_nx == DONE);
      res_we    <= (state_nx == WRITE);
      mac_clr_n <= (state_nx == FEED) || (state_nx == DRAIN) || (state_nx == WRITE);
      if (state_nx == WRITE) res_addr <= n;
      case (state)
        IDLE: begin
          if (start) begin
            n      <= '0;
            w_addr <= '0;
          end
        end
        CLEAR: begin
          in_addr   <= '0;
          drain_cnt <= 1'b0;
        end
        FEED: begin
          in_addr <= (in_addr == I_LAST) ? '0 : in_addr + 1'b1;
          w_addr  <= w_addr + 1'b1;
        end
        DRAIN: drain_cnt <= ~drain_cnt;
        WRITE: begin
          res_hold <= res_next;
          if (n != N_LAST) n <= n + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: memory and MAC models around the DUT, expected results and read
// addresses queued by the driver, popped by a monitor on each write / read issue.
module tb_mac_sequencer;

  localparam int NI = 16;
  localparam int NN = 8;
  localparam int IN_AW = 4;
  localparam int NEU_AW = 3;
  localparam int W_AW = 7;
  localparam int RUN_CYCLES = NN * (NI + 4) + 1;
  localparam logic [2:0] ST_FEED = 3'd2;
`ifdef SEQ_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [IN_AW-1:0]  in_addr;
  logic [W_AW-1:0]   w_addr;
  logic [15:0]       in_rdata;
  logic [15:0]       w_rdata;
  logic [15:0]       mac_value;
  logic [15:0]       mac_weight;
  logic              mac_clr_n;
  logic [15:0]       mac_out;
  logic              res_we;
  logic [NEU_AW-1:0] res_addr;
  logic [15:0]       res_data;
  logic [2:0]        state_dbg;

  mac_sequencer #(
    .N_INPUTS(NI), .N_NEURONS(NN), .IN_AW(IN_AW), .NEU_AW(NEU_AW), .W_AW(W_AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .w_addr(w_addr), .in_rdata(in_rdata), .w_rdata(w_rdata),
    .mac_value(mac_value), .mac_weight(mac_weight), .mac_clr_n(mac_clr_n),
    .mac_out(mac_out), .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- environment: synchronous memories and Q8.8 MAC ----------------
  logic [15:0]        in_mem [NI];
  logic [15:0]        w_mem  [NI*NN];
  logic signed [31:0] prod;
  logic signed [31:0] acc;

  always @(posedge clk) begin
    in_rdata <= in_mem[in_addr];
    w_rdata  <= w_mem[w_addr];
  end

  always @(posedge clk) begin
    if (!mac_clr_n) begin
      prod <= 32'sd0;
      acc  <= 32'sd0;
    end else begin
      prod <= $signed(mac_value) * $signed(mac_weight);
      acc  <= acc + prod;
    end
  end

  assign mac_out = acc[23:8];

  // ---------------- scoreboard ----------------
  logic [NEU_AW+15:0]     exp_q[$];
  logic [IN_AW+W_AW-1:0]  addr_q[$];
  logic [NEU_AW+15:0]     sb_e;
  logic [IN_AW+W_AW-1:0]  sb_a;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && res_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write: addr=%0d data=%h, no write expected", res_addr, res_data);
      end else begin
        sb_e = exp_q.pop_front();
        check("res_addr", 32'(res_addr), 32'(sb_e[NEU_AW+15:16]));
        check("res_data", 32'(res_data), 32'(sb_e[15:0]));
      end
    end
    if (reset === 1'b1 && state_dbg == ST_FEED) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_read: in_addr=%0d w_addr=%0d, no read expected", in_addr, w_addr);
      end else begin
        sb_a = addr_q.pop_front();
        check("in_addr", 32'(in_addr), 32'(sb_a[IN_AW+W_AW-1:W_AW]));
        check("w_addr", 32'(w_addr), 32'(sb_a[W_AW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] neg_res(input logic [15:0] v);
    return RELU ? 16'h0000 : v;
  endfunction

  // cfg 0: values 1.0, weight[a]=a raw      -> result k = 0x0078 + k*0x0100
  // cfg 1: values 1.0, weights (k+1)/16     -> result (k+1)*0x0100; neuron 7 weights -1/16 -> 0xFF00
  // cfg 2: values 0.5, weights -1.0 / 3.0   -> even k 0xF800, odd k 0x1800
  task automatic load_run(input int cfg);
    logic [15:0] r;
    for (int k = 0; k < NN; k++) begin
      for (int j = 0; j < NI; j++) begin
        case (cfg)
          0: begin in_mem[j] = 16'h0100; w_mem[k*NI+j] = 16'(k*NI + j); end
          1: begin
            in_mem[j] = 16'h0100;
            w_mem[k*NI+j] = (k < 7) ? 16'((k + 1) * 16) : 16'hFFF0;
          end
          default: begin
            in_mem[j] = 16'h0080;
            w_mem[k*NI+j] = (k % 2 == 0) ? 16'hFF00 : 16'h0300;
          end
        endcase
        addr_q.push_back({IN_AW'(j), W_AW'(k*NI + j)});
      end
      case (cfg)
        0:       r = 16'((k << 8) + 'h78);
        1:       r = (k < 7) ? 16'((k + 1) << 8) : neg_res(16'hFF00);
        default: r = (k % 2 == 0) ? neg_res(16'hF800) : 16'h1800;
      endcase
      exp_q.push_back({NEU_AW'(k), r});
    end
  endtask

  task automatic run_layer(input string tag, input int mid_start, input bit start_in_done);
    int cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cnt < RUN_CYCLES + 20) begin
      @(negedge clk);
      cnt++;
      start = (cnt == mid_start);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_done_latency"}, 32'(cnt), 32'(RUN_CYCLES));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_reads_left"}, 32'(addr_q.size()), 32'd0);
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_res_we"}, 32'(res_we), 32'd0);
    check({tag, "_res_addr"}, 32'(res_addr), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_in_addr"}, 32'(in_addr), 32'd0);
    check({tag, "_w_addr"}, 32'(w_addr), 32'd0);
    check({tag, "_mac_clr_n"}, 32'(mac_clr_n), 32'd0);
    check({tag, "_mac_value"}, 32'(mac_value), 32'd0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;

    // Address sweep over the full weight space
    load_run(0);
    run_layer("sweep", 0, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_res_addr", 32'(res_addr), 32'd7);
    check("hold_res_data", 32'(res_data), 32'h0778);

    // Per-neuron clear, negative result, start ignored mid-run and in DONE
    load_run(1);
    run_layer("clr", 50, 1'b1);

    // Asynchronous reset during neuron 1 FEED, then a complete run
    load_run(2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    check("abort_in_feed", 32'(state_dbg), 32'(ST_FEED));
    #2 reset = 1'b0;
    #1 check_reset_outputs("async");
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    load_run(2);
    run_layer("rerun", 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Sequencing controller for the Q8.8 multiply-accumulate unit used by the fully-connected layers.
- Each layer run is one dot product per neuron: N_NEURONS dot products of length N_INPUTS.
- The block issues input and weight memory reads, gates operands into the MAC and clears it between neurons.
- It captures each MAC result and writes it to the result memory, with a start/busy/done handshake to the layer controller.

Parameters:
- N_INPUTS, 16, dot-product length per neuron (>=1)
- N_NEURONS, 8, neurons per layer run (>=1)
- IN_AW, 4, input-memory address width; 2^IN_AW >= N_INPUTS
- NEU_AW, 3, neuron index / result address width; 2^NEU_AW >= N_NEURONS
- W_AW, 7, weight address width; 2^W_AW >= N_NEURONS*N_INPUTS

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to run a layer; ignored while busy
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the last result has been written
- in_addr  out  IN_AW  input (value) memory read address
- w_addr  out  W_AW  weight memory read address
- in_rdata  in  16  value read data; synchronous memory, 1-cycle latency
- w_rdata  in  16  weight read data; 1-cycle latency
- mac_value  out  16  signed operand to MAC value input
- mac_weight  out  16  signed operand to MAC weight input
- mac_clr_n  out  1  drives MAC synchronous active-low clear
- mac_out  in  16  MAC Q8.8 result (accumulator bits [23:8])
- res_we  out  1  result write strobe
- res_addr  out  NEU_AW  result address = neuron index
- res_data  out  16  result word

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, all counters 0, busy=0, done=0, res_we=0, res_addr=0, res_data=0, in_addr=0, w_addr=0, mac_clr_n=0, rd_valid=0.
- Reset mid-run aborts the run immediately; no done pulse.
- MAC model: product is registered 1 cycle after its operands; sum is registered 1 cycle after that. The MAC accumulates every cycle.
- Operands are therefore forced to 0 whenever they are not valid: mac_value = rd_valid ? in_rdata : 0 (same gating for mac_weight).
- rd_valid is a 1-cycle registered copy of "read issued".
- States:
  - IDLE: mac_clr_n=0. On start -> CLEAR; neuron counter n=0.
  - CLEAR (1 cycle): mac_clr_n=0; input counter i=0 -> FEED.
  - FEED (N_INPUTS cycles): mac_clr_n=1; issue in_addr=i, w_addr=n*N_INPUTS+i; i++. After i=N_INPUTS-1 -> DRAIN.
  - DRAIN (2 cycles): no reads; the last operand passes through product and sum -> WRITE.
  - WRITE (1 cycle): res_we=1, res_addr=n, res_data=f(mac_out). If n==N_NEURONS-1 -> DONE, else n++ -> CLEAR.
  - DONE (1 cycle): done=1, mac_clr_n=0 -> IDLE.
- Timing:
  - Per neuron: N_INPUTS+4 cycles.
  - Start-to-done: N_NEURONS*(N_INPUTS+4)+1 cycles.
  - mac_out is sampled in WRITE, exactly 2 cycles after the last read issue plus the memory latency.
- res_we, done and mac_clr_n are registered outputs, glitch-free.
- res_data and res_addr hold their values between writes.
- start coincident with DONE is ignored; start is accepted only in IDLE.
- N_INPUTS=1: FEED lasts 1 cycle; the DRAIN and WRITE timing is unchanged.
- Address arithmetic is unsigned.
- No overflow handling: MAC wrap behaviour passes through unchanged.

Optional Feature:
- Macro SEQ_RELU_EN.
- Defined: res_data = mac_out[15] ? 16'h0000 : mac_out (ReLU applied at write).
- Undefined: res_data = mac_out unmodified.
- Latency is identical in both builds.

Test Plan:
- Basic dot product: N_INPUTS=4, N_NEURONS=1, all values 16'h0100, all weights 16'h0100. After start -> one res_we with res_addr=0, res_data=16'h0400; done exactly 9 cycles after start is sampled.
- Clear between neurons: N_NEURONS=2; neuron0 weights 16'h0200, neuron1 weights 16'h0100, values 16'h0100. -> res 16'h0800 then 16'h0400; no carry-over from neuron0.
- Negative result: value 16'h0100, weights 16'hFF00 (N_INPUTS=4). -> 16'hFC00 with SEQ_RELU_EN undefined; 16'h0000 with it defined.
- Handshake: start pulsed again mid-run and in the DONE cycle -> ignored; busy stays high until after done; exactly N_NEURONS writes occur.
- Async reset: reset asserted during FEED of neuron1 (no clock edge) -> outputs go to reset values immediately. A subsequent start produces a complete, correct run.
- Address sweep: N_INPUTS=16, N_NEURONS=8 -> w_addr covers 0..127 once each, in_addr cycles 0..15 per neuron, res_addr 0..7 in order.
